adc_scan_ctrl: RTL and testbench

Upstream sequencer for the `spi` ADC master, paired with result averaging. It generates `spi_start` and the 3-bit channel address for each 32-edge SPI frame and round-robins through the enabled ADC channels. It collects the 12-bit conversion returned by the master and emits one averaged, channel-tagged result per channel visit. It accounts for the ADC pipeline: the data shifted in during frame k belongs to the address sent in frame k-1.

---
 rtl/adc_pkg.sv | 11 +
 rtl/adc_chan_pick.sv | 24 ++
 rtl/adc_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and sizing helpers for the ADC scan controller.
package adc_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, GAP, CAPTURE} state_e;
  localparam int AVG_LOG2_MAX = 4;
  function automatic int frame_cycles(input int sys_fre, input int spi_fre);
    return 32 * (sys_fre / spi_fre);
  endfunction
  function automatic int acc_width(input int data_width, input int avg_log2);
    return data_width + avg_log2;
  endfunction
endpackage

// File: rtl/adc_chan_pick.sv
// adc_chan_pick: combinational next-enabled-channel picker (lowest on restart, else next above cur with 7->0 wrap).
module adc_chan_pick (
  input  logic [2:0] cur_i,
  input  logic [7:0] mask_i,
  input  logic       first_i,
  output logic [2:0] nxt_o,
  output logic       none_o
);
  logic [2:0] idx;
  logic       found;
  always_comb begin
    nxt_o = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = first_i ? 3'(k) : 3'(cur_i + 3'(k + 1));
      if (!found && mask_i[idx]) begin
        nxt_o = idx;
        found = 1'b1;
      end
    end
  end
  assign none_o = ~|mask_i;
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: round-robin SPI ADC frame sequencer with pipeline-aware per-channel averaging.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SYS_FRE    = 50_000_000,
  parameter int SPI_FRE    = 1_000_000,
  parameter int GAP_CYCLES = 8,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  scan_en,
  input  logic [7:0]            chan_mask,
  input  logic [DATA_WIDTH-1:0] spi_data,
  output logic                  spi_start,
  output logic [2:0]            spi_addr,
  output logic                  result_valid,
  output logic [2:0]            result_chan,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  busy
);
  localparam int FRAME_CYCLES = frame_cycles(SYS_FRE, SPI_FRE);
  localparam int ACC_W = acc_width(DATA_WIDTH, AVG_LOG2);
  localparam int CNT_MAX = FRAME_CYCLES > GAP_CYCLES ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [4:0] NUM = 5'(1 << AVG_LOG2);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            addr_q, addr_d, prev_q, prev_d, acc_ch_q, acc_ch_d, res_ch_q, res_ch_d;
  logic [4:0]            vis_q, vis_d, smp_q, smp_d, smp_base;
  logic                  prime_q, prime_d, rv_q, rv_d, same, run;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_base, acc_sum;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [2:0]            pick_ch;
  logic                  pick_none;

  adc_chan_pick u_pick (
    .cur_i  (addr_q),
    .mask_i (chan_mask),
    .first_i(state_q == IDLE),
    .nxt_o  (pick_ch),
    .none_o (pick_none)
  );

  assign run = scan_en && !pick_none;
  // A new channel (or an emptied count) restarts the running sum from zero.
  assign same = (smp_q != 5'd0) && (acc_ch_q == prev_q);
  assign acc_base = same ? acc_q : '0;
  assign smp_base = same ? smp_q : 5'd0;
  assign acc_sum = acc_base + ACC_W'(spi_data);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    prev_d = prev_q;
    acc_ch_d = acc_ch_q;
    res_ch_d = res_ch_q;
    vis_d = vis_q;
    smp_d = smp_q;
    prime_d = prime_q;
    rv_d = 1'b0;
    acc_d = acc_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (run) begin
        state_d = FRAME;
        cnt_d = '0;
        addr_d = pick_ch;
        vis_d = 5'd0;
        smp_d = 5'd0;
        acc_d = '0;
        prime_d = 1'b0;
      end
      FRAME: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d = '0;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = CAPTURE;
          cnt_d = '0;
        end
      end
      CAPTURE: begin
        // The return just shifted in belongs to the frame before the one that ended.
        prev_d = addr_q;
        prime_d = 1'b1;
        if (prime_q) begin
          acc_ch_d = prev_q;
          if (smp_base + 5'd1 == NUM) begin
            rv_d = 1'b1;
            res_d = DATA_WIDTH'(acc_sum >> AVG_LOG2);
            res_ch_d = prev_q;
            acc_d = '0;
            smp_d = 5'd0;
          end else begin
            acc_d = acc_sum;
            smp_d = smp_base + 5'd1;
          end
        end
        state_d = run ? FRAME : IDLE;
        if (run) begin
          vis_d = (vis_q == NUM - 5'd1) ? 5'd0 : vis_q + 5'd1;
          addr_d = (vis_q == NUM - 5'd1) ? pick_ch : addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      prev_q <= '0;
      acc_ch_q <= '0;
      res_ch_q <= '0;
      vis_q <= '0;
      smp_q <= '0;
      prime_q <= 1'b0;
      rv_q <= 1'b0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      prev_q <= prev_d;
      acc_ch_q <= acc_ch_d;
      res_ch_q <= res_ch_d;
      vis_q <= vis_d;
      smp_q <= smp_d;
      prime_q <= prime_d;
      rv_q <= rv_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign spi_start = state_q == FRAME;
  assign busy = state_q != IDLE;
  assign spi_addr = addr_q;
  assign result_valid = rv_q;
  assign result_chan = res_ch_q;
  assign result_data = res_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: frame-table stimulus with a result scoreboard for AVG_LOG2=0 (u0) and AVG_LOG2=2 (u2) instances.
module tb_adc_scan_ctrl;
  typedef struct {
    logic [11:0] ret;
    logic [2:0]  addr;
    bit          res;
    logic [2:0]  ch;
    logic [11:0] dat;
    logic [8:0]  mmask;
    bit          stop;
  } vec_t;
  typedef struct {
    logic [2:0]  ch;
    logic [11:0] d;
  } res_t;

  logic clk = 0, rst_n = 0, en0 = 0, en2 = 0;
  logic [7:0] mask = 0;
  logic [11:0] sd = 0;
  logic st0, rv0, bz0, st2, rv2, bz2;
  logic [2:0] ad0, rc0, ad2, rc2;
  logic [11:0] rd0, rd2;
  int n_chk = 0, n_pass = 0, cyc = 0, last0 = -1, last2 = -1;
  bit per_chk = 0;
  res_t q0[$], q2[$];
  vec_t tab[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_scan_ctrl #(.DATA_WIDTH(12), .SYS_FRE(4), .SPI_FRE(1), .GAP_CYCLES(8), .AVG_LOG2(0)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .scan_en(en0), .chan_mask(mask), .spi_data(sd),
    .spi_start(st0), .spi_addr(ad0), .result_valid(rv0), .result_chan(rc0), .result_data(rd0), .busy(bz0));
  adc_scan_ctrl #(.DATA_WIDTH(12), .SYS_FRE(4), .SPI_FRE(1), .GAP_CYCLES(8), .AVG_LOG2(2)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .scan_en(en2), .chan_mask(mask), .spi_data(sd),
    .spi_start(st2), .spi_addr(ad2), .result_valid(rv2), .result_chan(rc2), .result_data(rd2), .busy(bz2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic st(input bit w); return w ? st2 : st0; endfunction
  function automatic logic bz(input bit w); return w ? bz2 : bz0; endfunction
  function automatic logic [2:0] ad(input bit w); return w ? ad2 : ad0; endfunction
  function automatic vec_t v(input logic [11:0] r, input logic [2:0] a, input bit res,
                             input logic [2:0] ch, input logic [11:0] d);
    vec_t x;
    x.ret = r; x.addr = a; x.res = res; x.ch = ch; x.dat = d; x.mmask = 9'd0; x.stop = 0;
    return x;
  endfunction

  task automatic set_en(input bit w, input logic val);
    if (w) en2 = val; else en0 = val;
  endtask

  always @(negedge clk) if (rst_n) begin
    res_t e;
    if (rv0) begin
      if (q0.size() == 0) check("unexpected_rv_u0", 1, 0);
      else begin e = q0.pop_front(); check("res_chan_u0", rc0, e.ch); check("res_data_u0", rd0, e.d); end
      if (per_chk && last0 >= 0) check("rv_period_u0", cyc - last0, 137);
      last0 = cyc;
    end
    if (rv2) begin
      if (q2.size() == 0) check("unexpected_rv_u2", 1, 0);
      else begin e = q2.pop_front(); check("res_chan_u2", rc2, e.ch); check("res_data_u2", rd2, e.d); end
      last2 = cyc;
    end
  end

  task automatic run_frame(input bit w, input vec_t x);
    int n;
    bit stable;
    res_t r;
    n = 0;
    while (!st(w) && n < 400) begin @(negedge clk); n++; end
    if (!st(w)) begin check("start_timeout", 0, 1); return; end
    check("frame_addr", ad(w), x.addr);
    n = 0;
    stable = 1;
    while (st(w) && n < 400) begin
      if (n == 50 && x.mmask[8]) mask = x.mmask[7:0];
      if (n == 50 && x.stop) set_en(w, 0);
      if (ad(w) != x.addr) stable = 0;
      n++;
      @(negedge clk);
    end
    check("start_len", n, 128);
    check("addr_stable", stable, 1);
    sd = x.ret;
    if (x.res) begin
      r.ch = x.ch; r.d = x.dat;
      if (w) q2.push_back(r); else q0.push_back(r);
    end
  endtask

  task automatic run_seq(input bit w);
    int n;
    set_en(w, 1);
    foreach (tab[i]) run_frame(w, tab[i]);
    set_en(w, 0);
    n = 0;
    while (bz(w) && n < 400) begin n++; @(negedge clk); end
    check("gap_capture_tail", n, 9);
    repeat (3) @(negedge clk);
    check("sb_empty", w ? q2.size() : q0.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 0; en0 = 0; en2 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit any;
    do_reset();
    check("reset_u0", {st0, ad0, rv0, rc0, rd0, bz0}, 0);
    check("reset_u2", {st2, ad2, rv2, rc2, rd2, bz2}, 0);

    // single channel, no averaging: prime frame silent, then a result every frame period
    mask = 8'h01; per_chk = 1; last0 = -1;
    tab = {};
    tab.push_back(v(12'hABC, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tab.push_back(v(12'hABC, 0, 1, 0, 12'hABC));
    run_seq(0);
    per_chk = 0;

    // two channels, 4-sample averaging, one-frame pipeline offset
    do_reset();
    mask = 8'h05;
    tab = {};
    tab.push_back(v(0, 0, 0, 0, 0));
    tab.push_back(v(100, 0, 0, 0, 0));
    tab.push_back(v(101, 0, 0, 0, 0));
    tab.push_back(v(102, 0, 0, 0, 0));
    tab.push_back(v(105, 2, 1, 0, 102));
    tab.push_back(v(200, 2, 0, 0, 0));
    tab.push_back(v(200, 2, 0, 0, 0));
    tab.push_back(v(200, 2, 0, 0, 0));
    tab.push_back(v(204, 0, 1, 2, 201));
    run_seq(1);

    // empty mask never starts
    do_reset();
    mask = 8'h00; en0 = 1; en2 = 1; any = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bz0 | bz2 | st0 | st2 | rv0 | rv2) any = 1;
    end
    check("empty_mask_idle", any, 0);
    en0 = 0; en2 = 0;

    // mid-frame stop with a partial average, then a restart must start fresh
    do_reset();
    mask = 8'h01;
    tab = {};
    tab.push_back(v(7, 0, 0, 0, 0));
    tab.push_back(v(999, 0, 0, 0, 0));
    tab[1].stop = 1;
    run_seq(1);
    tab = {};
    tab.push_back(v(0, 0, 0, 0, 0));
    tab.push_back(v(10, 0, 0, 0, 0));
    tab.push_back(v(20, 0, 0, 0, 0));
    tab.push_back(v(30, 0, 0, 0, 0));
    tab.push_back(v(40, 0, 1, 0, 25));
    run_seq(1);

    // mask change mid-frame takes effect at the next selection, 7 wraps to 0
    do_reset();
    mask = 8'h80;
    tab = {};
    tab.push_back(v(11, 7, 0, 0, 0));
    tab[0].mmask = 9'h181;
    tab.push_back(v(22, 0, 1, 7, 22));
    tab.push_back(v(33, 7, 1, 0, 33));
    tab.push_back(v(44, 0, 1, 7, 44));
    run_seq(0);

    // reset mid-frame, then a fresh prime frame with no stale result
    do_reset();
    mask = 8'h01;
    en0 = 1;
    tab = {};
    tab.push_back(v(12'h111, 0, 0, 0, 0));
    tab.push_back(v(12'h123, 0, 1, 0, 12'h123));
    foreach (tab[i]) run_frame(0, tab[i]);
    n = 0;
    while (!st0 && n < 400) begin @(negedge clk); n++; end
    check("pre_reset_frame", st0, 1);
    repeat (50) @(negedge clk);
    rst_n = 0;
    #1;
    check("reset_midframe_u0", {st0, ad0, rv0, rc0, rd0, bz0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("reset_sb_empty", q0.size(), 0);
    tab = {};
    tab.push_back(v(12'h055, 0, 0, 0, 0));
    tab.push_back(v(12'h066, 0, 1, 0, 12'h066));
    run_seq(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
